// File: rtl/act_pkg.sv
// Shared types, tanh breakpoints and the tanh helper for the activation scheduler.
// Q4.12 signed operands; piecewise-linear tanh saturating at +/-1.0.
package act_pkg;

  localparam int ACT_DATA_W    = 16;
  localparam int ACT_TAG_W_MAX = 8;
  localparam int ACT_ID_W_MAX  = 3;

  typedef logic signed [ACT_DATA_W-1:0] act_q412_t;

  localparam logic [15:0] ACT_BP0  = 16'h0800;
  localparam logic [15:0] ACT_BP1  = 16'h1333;
  localparam logic [15:0] ACT_BP2  = 16'h2666;
  localparam logic [15:0] ACT_OFF1 = 16'h0400;
  localparam logic [15:0] ACT_OFF2 = 16'h0B33;
  localparam logic [15:0] ACT_ONE  = 16'h1000;

  typedef struct packed {
    act_q412_t                 data;
    logic [ACT_TAG_W_MAX-1:0]  tag;
    logic [ACT_ID_W_MAX-1:0]   id;
  } act_stage_t;

  // Magnitude is taken as unsigned so 0x8000 lands in the saturating segment.
  function automatic act_q412_t act_tanh(input act_q412_t v);
    logic [15:0] x;
    logic [15:0] y;
    x = v[15] ? (16'd0 - 16'(v)) : 16'(v);
    if (x < ACT_BP0) begin
      y = x;
    end else if (x < ACT_BP1) begin
      y = (x >> 1) + ACT_OFF1;
    end else if (x < ACT_BP2) begin
      y = (x >> 3) + ACT_OFF2;
    end else begin
      y = ACT_ONE;
    end
    return v[15] ? act_q412_t'(16'd0 - y) : act_q412_t'(y);
  endfunction

endpackage

// File: rtl/act_rr_arb.sv
// Parametric round-robin arbiter: lowest set request at or above the pointer wins,
// wrapping modulo N.
module act_rr_arb
  import act_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_grant,
  output logic [IDW-1:0] o_idx,
  output logic           o_any
);

  logic [2*N-1:0] w_rot2;
  logic [N-1:0]   w_rot;
  logic [IDW-1:0] w_off;
  logic [IDW:0]   w_sum;

  // Rotate requests so the pointer position is bit 0, then pick the first set bit.
  always_comb begin
    w_rot2 = {i_req, i_req} >> i_ptr;
    w_rot  = w_rot2[N-1:0];
    w_off  = {IDW{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      w_off = w_rot[k] ? IDW'(k) : w_off;
    end
    w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
    o_idx   = (w_sum >= (IDW+1)'(N)) ? IDW'(w_sum - (IDW+1)'(N)) : IDW'(w_sum);
    o_any   = |i_req;
    o_grant = o_any ? (N'(1) << o_idx) : {N{1'b0}};
  end

endmodule

// File: rtl/act_rr_sched.sv
// Round-robin scheduler sharing one tanh unit among N_REQ requesters through a
// two-stage valid/ready pipeline (capture, then compute and hold the response).
module act_rr_sched
  import act_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4,
  parameter int IDW    = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [IDW-1:0]          rsp_id,
  output logic [TAG_W-1:0]        rsp_tag,
  input  logic                    rsp_ready,
  output logic [1:0]              inflight
);

  logic             r_s1_valid;
  logic             r_s2_valid;
  act_stage_t       r_s1;
  act_stage_t       r_s2;
  logic [IDW-1:0]   r_rr_ptr;

  logic             w_rdy1;
  logic             w_rdy2;
  logic             w_accept;
  logic [N_REQ-1:0] w_grant;
  logic [IDW-1:0]   w_idx;
  logic             w_any;
  logic [DATA_W-1:0] w_data_sel;
  logic [TAG_W-1:0]  w_tag_sel;
  logic [IDW-1:0]   w_ptr_next;

  act_rr_arb #(.N(N_REQ), .IDW(IDW)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Handshake readiness, operand selection and next pointer.
  always_comb begin
    w_rdy2     = ~r_s2_valid | rsp_ready;
    w_rdy1     = ~r_s1_valid | w_rdy2;
    w_accept   = rst_n & w_rdy1 & w_any;
    req_ready  = w_grant & {N_REQ{w_accept}};
    w_data_sel = req_data[w_idx*DATA_W +: DATA_W];
    w_tag_sel  = req_tag[w_idx*TAG_W +: TAG_W];
    w_ptr_next = (w_idx == IDW'(N_REQ - 1)) ? {IDW{1'b0}} : (w_idx + IDW'(1));
  end

  // Pipeline state; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s1       <= '0;
      r_s2       <= '0;
      r_rr_ptr   <= {IDW{1'b0}};
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1.data  <= act_q412_t'(w_data_sel);
        r_s1.tag   <= ACT_TAG_W_MAX'(w_tag_sel);
        r_s1.id    <= ACT_ID_W_MAX'(w_idx);
        r_rr_ptr   <= w_ptr_next;
      end else if (w_rdy1) begin
        r_s1_valid <= 1'b0;
      end
      if (r_s1_valid && w_rdy2) begin
        r_s2_valid <= 1'b1;
        r_s2.data  <= act_tanh(r_s1.data);
        r_s2.tag   <= r_s1.tag;
        r_s2.id    <= r_s1.id;
      end else if (w_rdy2) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_s2_valid;
  assign rsp_data  = DATA_W'(r_s2.data);
  assign rsp_id    = r_s2.id[IDW-1:0];
  assign rsp_tag   = r_s2.tag[TAG_W-1:0];
  assign inflight  = {1'b0, r_s1_valid} + {1'b0, r_s2_valid};

endmodule

// File: tb/tb_act_rr_sched.sv
// Scoreboard bench for act_rr_sched: a cycle model predicts grants/occupancy and
// queues expected responses at accept time, popped when the response handshakes.
module tb_act_rr_sched;

  localparam int N = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*16-1:0] req_data;
  logic [N*4-1:0]  req_tag;
  logic [N-1:0]  req_ready;
  logic          rsp_valid;
  logic [15:0]   rsp_data;
  logic [1:0]    rsp_id;
  logic [3:0]    rsp_tag;
  logic          rsp_ready;
  logic [1:0]    inflight;

  act_rr_sched #(.N_REQ(N), .DATA_W(16), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_tag   (req_tag),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_tag   (rsp_tag),
    .rsp_ready (rsp_ready),
    .inflight  (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  logic        m_s1v   = 1'b0;
  logic        m_s2v   = 1'b0;
  int          m_ptr   = 0;
  logic        m_known = 1'b0;
  logic [21:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_tanh(input logic [15:0] v);
    logic [15:0] x;
    logic [15:0] y;
    x = v[15] ? (16'd0 - v) : v;
    if (x < 16'h0800)      y = x;
    else if (x < 16'h1333) y = (x >> 1) + 16'h0400;
    else if (x < 16'h2666) y = (x >> 3) + 16'h0B33;
    else                   y = 16'h1000;
    return v[15] ? (16'd0 - y) : y;
  endfunction

  // One clock: check DUT against the model mid-cycle, then advance the model.
  task automatic tick();
    logic rdy1, rdy2, any, acc;
    int   g;
    logic [3:0] exp_rdy;
    @(negedge clk);
    rdy2 = !m_s2v || rsp_ready;
    rdy1 = !m_s1v || rdy2;
    any  = |req_valid;
    g    = 0;
    for (int k = N - 1; k >= 0; k--)
      if (req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    acc     = rst_n && rdy1 && any;
    exp_rdy = acc ? 4'(1 << g) : 4'd0;
    chk("req_ready", req_ready, exp_rdy);
    if (m_known) begin
      chk("rsp_valid", rsp_valid, m_s2v);
      chk("inflight", inflight, 2'(m_s1v) + 2'(m_s2v));
      if (m_s2v) begin
        if (sb_q.size() == 0) chk("sb_under", 1, 0);
        else if (rsp_ready) chk("rsp", {rsp_data, rsp_id, rsp_tag}, sb_q.pop_front());
        else chk("rsp_hold", {rsp_data, rsp_id, rsp_tag}, sb_q[0]);
      end
    end
    if (!rst_n) begin
      m_s1v = 1'b0; m_s2v = 1'b0; m_ptr = 0; m_known = 1'b1;
      sb_q.delete();
    end else begin
      m_s2v = (m_s1v && rdy2) ? 1'b1 : (rdy2 ? 1'b0 : m_s2v);
      m_s1v = acc ? 1'b1 : (rdy1 ? 1'b0 : m_s1v);
      if (acc) begin
        sb_q.push_back({m_tanh(req_data[g*16 +: 16]), 2'(g), req_tag[g*4 +: 4]});
        m_ptr = (g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    req_data = {$urandom, $urandom};
    req_tag  = 16'($urandom);
  endtask

  logic [15:0] vals[6] = '{16'h0400, 16'h1000, 16'h2000, 16'h3000, 16'hF000, 16'h8000};

  initial begin
    rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 1'b1;
    req_data = '0; req_tag = '0;
    // Reset held with all requesters asking
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    rand_ops();
    tick();
    req_valid = 4'h0;
    for (int i = 0; i < 3; i++) tick();

    // Spot values through requester 0
    req_valid = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      req_data[15:0] = vals[i];
      req_tag[3:0]   = 4'(i + 1);
      tick();
    end
    req_valid = 4'h0;
    for (int i = 0; i < 3; i++) tick();

    // Fairness with all requesters valid
    req_valid = 4'hF;
    for (int i = 0; i < 12; i++) begin rand_ops(); tick(); end
    req_valid = 4'h0;
    for (int i = 0; i < 3; i++) tick();

    // Backpressure: fill, hold, then drain
    rsp_ready = 1'b0; req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin rand_ops(); tick(); end
    rsp_ready = 1'b1; req_valid = 4'h0;
    for (int i = 0; i < 4; i++) tick();

    // Pointer wrap and skip
    rand_ops();
    req_valid = 4'b1000; tick();
    req_valid = 4'b1001; tick(); tick();
    req_valid = 4'h0;
    for (int i = 0; i < 3; i++) tick();

    // Reset with two items in flight
    rsp_ready = 1'b0; req_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin rand_ops(); tick(); end
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req_valid = 4'h0; rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    req_valid = 4'hF; rand_ops(); tick();
    req_valid = 4'h0;
    for (int i = 0; i < 3; i++) tick();

    // Random valid/ready traffic
    for (int i = 0; i < 80; i++) begin
      rand_ops();
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 4'h0; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
